// File: rtl/adbg_syncfifo.sv
// Synchronous first-word-fall-through FIFO (circular buffer) for the debug JTAG/bus data paths.
// Optional sticky OVERFLOW/UNDERFLOW registers are enabled by defining ADBG_SYNCFIFO_ERRFLAGS_EN.
module adbg_syncfifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FLUSH,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  PUSH,
    input  logic                  POP,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic [CNT_WIDTH-1:0]  WORDS_AVAIL,
    output logic [CNT_WIDTH-1:0]  WORDS_FREE,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] ONE_C    = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic                  full;
    logic                  empty;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  clear;

    always_comb begin
        full    = (count == DEPTH_C);
        empty   = (count == '0);
        clear   = RST | FLUSH;
        // A pop on a full FIFO frees the slot the simultaneous push lands in.
        push_ok = PUSH & (~full | POP);
        pop_ok  = POP & ~empty;
    end

    always_ff @(posedge CLK) begin
        if (!clear && push_ok) begin
            mem[wr_ptr] <= DATA_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

`ifdef ADBG_SYNCFIFO_ERRFLAGS_EN
    logic ovf_q;
    logic unf_q;

    always_ff @(posedge CLK) begin
        if (clear) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (PUSH && !push_ok) begin
                ovf_q <= 1'b1;
            end
            if (POP && !pop_ok) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = unf_q;
`else
    assign OVERFLOW  = 1'b0;
    assign UNDERFLOW = 1'b0;
`endif

    assign DATA_OUT    = empty ? '0 : mem[rd_ptr];
    assign WORDS_AVAIL = count;
    assign WORDS_FREE  = DEPTH_C - count;
    assign FULL        = full;
    assign EMPTY       = empty;

endmodule

// File: tb/tb_adbg_syncfifo.sv
// Directed scoreboard bench for adbg_syncfifo: an 8x8 instance and a 5x12 instance sharing clock and reset.
module tb_adbg_syncfifo;

`ifdef ADBG_SYNCFIFO_ERRFLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;

    logic        flush8 = 1'b0, push8 = 1'b0, pop8 = 1'b0;
    logic [7:0]  din8 = '0;
    logic [7:0]  dout8;
    logic [3:0]  avail8, free8;
    logic        full8, empty8, ovf8, unf8;

    logic        flush5 = 1'b0, push5 = 1'b0, pop5 = 1'b0;
    logic [11:0] din5 = '0;
    logic [11:0] dout5;
    logic [2:0]  avail5, free5;
    logic        full5, empty5, ovf5, unf5;

    adbg_syncfifo #(.DATA_WIDTH(8), .DEPTH(8)) u_fifo8 (
        .CLK(CLK), .RST(RST), .FLUSH(flush8), .DATA_IN(din8), .PUSH(push8), .POP(pop8),
        .DATA_OUT(dout8), .WORDS_AVAIL(avail8), .WORDS_FREE(free8), .FULL(full8),
        .EMPTY(empty8), .OVERFLOW(ovf8), .UNDERFLOW(unf8)
    );

    adbg_syncfifo #(.DATA_WIDTH(12), .DEPTH(5)) u_fifo5 (
        .CLK(CLK), .RST(RST), .FLUSH(flush5), .DATA_IN(din5), .PUSH(push5), .POP(pop5),
        .DATA_OUT(dout5), .WORDS_AVAIL(avail5), .WORDS_FREE(free5), .FULL(full5),
        .EMPTY(empty5), .OVERFLOW(ovf5), .UNDERFLOW(unf5)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    bit          sel = 1'b0;   // 0: 8x8 instance, 1: 5x12 instance
    logic [11:0] q[$];         // scoreboard of words expected on DATA_OUT
    logic        e_ovf = 1'b0;
    logic        e_unf = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare current outputs against the model, then drive one cycle of stimulus.
    task automatic step(input bit push, input bit pop, input bit flush, input logic [11:0] din);
        int          depth;
        bit          push_ok, pop_ok;
        logic [11:0] head;
        @(negedge CLK);
        depth = sel ? 5 : 8;
        head  = (q.size() != 0) ? q[0] : 12'h000;
        if (sel) begin
            check("dout5",  32'(dout5),  32'(head));
            check("avail5", 32'(avail5), 32'(q.size()));
            check("free5",  32'(free5),  32'(depth - q.size()));
            check("full5",  32'(full5),  32'(q.size() == depth));
            check("empty5", 32'(empty5), 32'(q.size() == 0));
            check("ovf5",   32'(ovf5),   32'(e_ovf));
            check("unf5",   32'(unf5),   32'(e_unf));
            push5 = push; pop5 = pop; flush5 = flush; din5 = din;
        end else begin
            check("dout8",  32'(dout8),  32'(head));
            check("avail8", 32'(avail8), 32'(q.size()));
            check("free8",  32'(free8),  32'(depth - q.size()));
            check("full8",  32'(full8),  32'(q.size() == depth));
            check("empty8", 32'(empty8), 32'(q.size() == 0));
            check("ovf8",   32'(ovf8),   32'(e_ovf));
            check("unf8",   32'(unf8),   32'(e_unf));
            push8 = push; pop8 = pop; flush8 = flush; din8 = din[7:0];
        end
        if (flush) begin
            q.delete();
            e_ovf = 1'b0;
            e_unf = 1'b0;
        end else begin
            push_ok = push && ((q.size() < depth) || pop);
            pop_ok  = pop && (q.size() != 0);
            if (pop_ok)  void'(q.pop_front());
            if (push_ok) q.push_back(sel ? din : {4'h0, din[7:0]});
            if (FLAGS_EN && push && !push_ok) e_ovf = 1'b1;
            if (FLAGS_EN && pop && !pop_ok)   e_unf = 1'b1;
        end
        @(posedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        push8 = 1'b0; pop8 = 1'b0; flush8 = 1'b0;
        push5 = 1'b0; pop5 = 1'b0; flush5 = 1'b0;
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        q.delete();
        e_ovf = 1'b0;
        e_unf = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        sel = 1'b0;
        step(0, 0, 0, 12'h0);                                 // post-reset state
        for (int i = 1; i <= 8; i++) step(1, 0, 0, 12'(8'h11 * i));
        for (int i = 0; i < 8; i++) step(0, 1, 0, 12'h0);     // FULL seen, then ordered drain
        step(0, 0, 0, 12'h0);

        for (int i = 1; i <= 8; i++) step(1, 0, 0, 12'(8'h11 * i));
        step(1, 0, 0, 12'h099);                               // dropped while full
        step(1, 1, 0, 12'h0AA);                               // full push+pop
        for (int i = 0; i < 8; i++) step(0, 1, 0, 12'h0);
        step(0, 0, 0, 12'h0);

        step(1, 1, 0, 12'h05A);                               // empty push+pop: no bypass
        step(0, 0, 0, 12'h0);
        step(1, 1, 1, 12'h077);                               // flush wins over strobes
        step(0, 1, 0, 12'h0);                                 // lone pop on empty
        step(0, 0, 0, 12'h0);

        step(1, 0, 0, 12'h0C1);
        step(1, 0, 0, 12'h0C2);
        step(1, 0, 0, 12'h0C3);
        do_reset();                                           // reset mid-stream
        step(0, 0, 0, 12'h0);
        step(1, 0, 0, 12'h0D4);
        step(0, 1, 0, 12'h0);
        step(0, 0, 0, 12'h0);

        sel = 1'b1;
        do_reset();
        for (int i = 1; i <= 5; i++) step(1, 0, 0, 12'(i));
        for (int i = 6; i <= 13; i++) step(1, 1, 0, 12'(i));  // FULL checked first, then wrap
        for (int i = 0; i < 5; i++) step(0, 1, 0, 12'h0);
        step(0, 0, 0, 12'h0);

        @(negedge CLK);
        push5 = 1'b0; pop5 = 1'b0;
        check("drained", 32'(q.size()), 32'(avail5));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adbg_syncfifo.md
# adbg_syncfifo

Parametrised synchronous first-word-fall-through FIFO for the debug interface's JTAG-to-bus data paths. It is the generalised successor to the fixed 8 x 8-bit byte FIFO: configurable width and depth, independent push and pop strobes accepted in the same cycle, a synchronous flush, and full/empty status with optional sticky overflow/underflow error flags. It is a circular buffer with read/write pointers, not a shift register, and sits between the TAP-side shift logic and the WishBone master in each debug module.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each stored word (>= 1)
- DEPTH, 8, number of entries (>= 2; need not be a power of two)
- CNT_WIDTH, $clog2(DEPTH+1), width of the count outputs (derived; not overridden)

Ports:
- CLK  input  1  clock; all state changes on rising edge
- RST  input  1  reset; synchronous, active-high
- FLUSH  input  1  synchronous clear of contents and flags
- DATA_IN  input  DATA_WIDTH  word to write
- PUSH  input  1  write strobe
- POP  input  1  read strobe; consumes the word currently on DATA_OUT
- DATA_OUT  output  DATA_WIDTH  oldest stored word (first-word-fall-through)
- WORDS_AVAIL  output  CNT_WIDTH  entries stored
- WORDS_FREE  output  CNT_WIDTH  DEPTH - WORDS_AVAIL
- FULL  output  1  WORDS_AVAIL == DEPTH
- EMPTY  output  1  WORDS_AVAIL == 0
- OVERFLOW  output  1  sticky: push attempted while full and not accepted
- UNDERFLOW  output  1  sticky: pop attempted while empty and not accepted

## Operation
- State: storage array (not reset), wr_ptr, rd_ptr (range 0..DEPTH-1), count (0..DEPTH), two sticky flags.
- Priority per edge: RST > FLUSH > push/pop.
- RST or FLUSH: wr_ptr = rd_ptr = count = 0, OVERFLOW = UNDERFLOW = 0; storage untouched; PUSH/POP that cycle ignored.
- push_ok = PUSH & (~FULL | POP). pop_ok = POP & ~EMPTY.
- push_ok: mem[wr_ptr] <= DATA_IN, wr_ptr advances. pop_ok: rd_ptr advances.
- Pointer advance: DEPTH-1 wraps to 0 (explicit compare, not modulo-2^n).
- count: +1 on push_ok only, -1 on pop_ok only, unchanged when both or neither.
- Full and PUSH & POP: both accepted; write lands in slot vacated by the pop; count stays DEPTH; no overflow.
- Empty and PUSH & POP: push accepted, pop rejected (no bypass); count becomes 1; UNDERFLOW set.
- PUSH while full without POP: write dropped, state unchanged, OVERFLOW set.
- POP while empty without PUSH: ignored, UNDERFLOW set.
- DATA_OUT = mem[rd_ptr] when count != 0, else all zeros (never X).
- FULL, EMPTY, WORDS_AVAIL, WORDS_FREE decoded combinationally from registered count.

## Timing
- Reset values: DATA_OUT 0, WORDS_AVAIL 0, WORDS_FREE DEPTH, EMPTY 1, FULL 0, OVERFLOW 0, UNDERFLOW 0.
- Write latency: word pushed on edge N is on DATA_OUT in the cycle after edge N if FIFO was empty.
- Pop: DATA_OUT in cycle before edge N is the consumed word; next word (or 0) is visible after edge N.
- Status outputs update one edge after the causing strobe; no combinational path from PUSH/POP to any output.
- Sticky flags set on the edge of the offending strobe; cleared only by RST or FLUSH.
- Reset/flush mid-stream: contents discarded on that edge; following cycle behaves as post-reset.

## Configuration
- ADBG_SYNCFIFO_ERRFLAGS_EN defined: OVERFLOW/UNDERFLOW registers implemented as above.
- Not defined: flag registers omitted, OVERFLOW and UNDERFLOW tied to 0; all other behaviour (drop on full, ignore on empty) identical. Ports exist in both builds.

## Test plan
- Reset then idle, DEPTH=8, DATA_WIDTH=8: DATA_OUT=0x00, WORDS_AVAIL=0, WORDS_FREE=8, EMPTY=1, FULL=0, flags 0.
- Push 0x11..0x88 (8 words), then pop 8: FULL=1 after 8th push; pops return 0x11,0x22,...,0x88 in order; EMPTY=1 at end, DATA_OUT=0x00.
- Full, push 0x99 alone -> dropped, OVERFLOW=1, count 8; then PUSH+POP with 0xAA -> DATA_OUT 0x11 consumed, count stays 8, later drain ends with 0xAA.
- Empty, PUSH+POP with 0x5A -> WORDS_AVAIL=1, DATA_OUT=0x5A, UNDERFLOW=1; FLUSH -> count 0, UNDERFLOW=0, DATA_OUT=0x00.
- DEPTH=5, DATA_WIDTH=12: 13 push/pop pairs over pointer wrap, data 0x001..0x00D in order, no flags; FULL at 5 entries, WORDS_FREE=0.
- Build without ADBG_SYNCFIFO_ERRFLAGS_EN: repeat overflow/underflow stimuli -> flags remain 0, data and counts identical to flagged build.
